// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and flag bit positions shared by the handshaked ALU
package alu_pkg;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_RESP = 2'd2} state_e;
  localparam int F_C = 0;
  localparam int F_V = 1;
  localparam int F_Z = 2;
  localparam int F_N = 3;
  localparam int F_I = 4;
  localparam int NFLAG = 5;
endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: W-cycle shift-add unsigned multiplier, LSB of b first, with start/done
module alu_seq_mul #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic           done_o,
  output logic [2*W-1:0] prod_o
);
  localparam int CW = $clog2(W);
  logic [2*W-1:0] mc_q, acc_q;
  logic [W-1:0] mp_q;
  logic [CW-1:0] cnt_q;
  logic busy_q;
  // prod_o is the accumulator after the current iteration, so it is final when done_o is high
  assign prod_o = acc_q + (mp_q[0] ? mc_q : '0);
  assign done_o = busy_q && (cnt_q == CW'(W - 1));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mc_q   <= '0;
      acc_q  <= '0;
      mp_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      mc_q   <= {{W{1'b0}}, a_i};
      acc_q  <= '0;
      mp_q   <= b_i;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      acc_q  <= prod_o;
      mc_q   <= mc_q << 1;
      mp_q   <= mp_q >> 1;
      cnt_q  <= cnt_q + 1'b1;
      busy_q <= !done_o;
    end
  end
endmodule

// File: rtl/alu_hs.sv
// alu_hs: registered W-bit ALU with valid/ready handshakes, full flags and optional iterative multiply
module alu_hs
  import alu_pkg::*;
#(
  parameter int W      = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         carry,
  output logic         overflow,
  output logic         zero,
  output logic         negative,
  output logic         illegal
);
  state_e state_q, state_d;
  logic live_q;
  logic [W-1:0] res_q, res_d, alu_r, upd_r;
  logic [NFLAG-1:0] flg_q, flg_d;
  logic [W:0] sum, diff;
  logic [2*W-1:0] prod;
  logic alu_c, alu_v, alu_ill, upd_c, upd_v, upd_i, upd;
  logic acc, is_mul, mul_start, mul_done;
  assign is_mul   = MUL_EN && (op == OP_MUL);
  // live_q keeps in_ready low until the first edge after reset is released
  assign in_ready = live_q && (state_q == S_IDLE || (state_q == S_RESP && out_ready));
  assign acc      = in_valid && in_ready;
  assign sum      = {1'b0, a} + {1'b0, b};
  assign diff     = {1'b0, a} - {1'b0, b};
  always_comb begin
    alu_r   = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (op)
      OP_ADD: begin
        alu_r = sum[W-1:0];
        alu_c = sum[W];
        alu_v = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      OP_SUB: begin
        alu_r = diff[W-1:0];
        alu_c = diff[W];
        alu_v = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
      end
      OP_XOR:  alu_r = a ^ b;
      OP_OR:   alu_r = a | b;
      OP_AND:  alu_r = a & b;
      OP_SHL:  alu_r = a << b;
      OP_SHR:  alu_r = a >> b;
      default: alu_ill = !MUL_EN;
    endcase
  end
  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    upd       = 1'b0;
    upd_r     = alu_r;
    upd_c     = alu_c;
    upd_v     = alu_v;
    upd_i     = alu_ill;
    if (state_q == S_MUL) begin
      if (mul_done) begin
        state_d = S_RESP;
        upd     = 1'b1;
        upd_r   = prod[W-1:0];
        upd_c   = |prod[2*W-1:W];
        upd_v   = 1'b0;
        upd_i   = 1'b0;
      end
    end else if (acc) begin
      state_d   = is_mul ? S_MUL : S_RESP;
      mul_start = is_mul;
      upd       = !is_mul;
    end else if (state_q == S_RESP && out_ready) begin
      state_d = S_IDLE;
    end
    res_d = upd ? upd_r : res_q;
    flg_d = flg_q;
    if (upd) begin
      flg_d[F_C] = upd_c;
      flg_d[F_V] = upd_v;
      flg_d[F_Z] = ~|upd_r;
      flg_d[F_N] = upd_r[W-1];
      flg_d[F_I] = upd_i;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      live_q  <= 1'b0;
      res_q   <= '0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      res_q   <= res_d;
      flg_q   <= flg_d;
    end
  end
  generate
    if (MUL_EN) begin : g_mul
      alu_seq_mul #(.W(W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start_i (mul_start),
        .a_i     (a),
        .b_i     (b),
        .done_o  (mul_done),
        .prod_o  (prod)
      );
    end else begin : g_nomul
      logic unused_start;
      assign unused_start = mul_start;
      assign mul_done     = 1'b0;
      assign prod         = '0;
    end
  endgenerate
  assign out_valid = (state_q == S_RESP);
  assign result    = res_q;
  assign carry     = flg_q[F_C];
  assign overflow  = flg_q[F_V];
  assign zero      = flg_q[F_Z];
  assign negative  = flg_q[F_N];
  assign illegal   = flg_q[F_I];
endmodule

// File: tb/tb_alu_hs.sv
// tb_alu_hs: randomized and directed checks of alu_hs against an arithmetic reference model
module tb_alu_hs;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic in_valid = 1'b0, out_ready = 1'b1;
  logic [7:0] a = '0, b = '0;
  logic [2:0] op = '0;
  logic in_ready, out_valid, carry, overflow, zero, negative, illegal;
  logic [7:0] result;
  logic n_in_valid = 1'b0, n_out_ready = 1'b1;
  logic [7:0] n_a = '0, n_b = '0;
  logic [2:0] n_op = '0;
  logic n_in_ready, n_out_valid, n_carry, n_overflow, n_zero, n_negative, n_illegal;
  logic [7:0] n_result;
  int n_chk = 0, n_pass = 0;

  alu_hs #(.W(8), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .carry(carry),
    .overflow(overflow), .zero(zero), .negative(negative), .illegal(illegal)
  );
  alu_hs #(.W(8), .MUL_EN(1'b0)) dut_nomul (
    .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready), .a(n_a), .b(n_b), .op(n_op),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .result(n_result), .carry(n_carry),
    .overflow(n_overflow), .zero(n_zero), .negative(n_negative), .illegal(n_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // {illegal, negative, zero, overflow, carry, result[7:0]}
  function automatic logic [12:0] model(input int x, input int y, input int code, input bit men);
    int r, sx, sy;
    bit c, v, ill;
    logic [7:0] r8;
    r = 0; c = 0; v = 0; ill = 0;
    sx = x >= 128 ? x - 256 : x;
    sy = y >= 128 ? y - 256 : y;
    case (code)
      0: begin r = x + y; c = r > 255; v = (sx + sy > 127) || (sx + sy < -128); end
      1: begin r = x - y; c = x < y; v = (sx - sy > 127) || (sx - sy < -128); end
      2: r = x ^ y;
      3: r = x | y;
      4: r = x & y;
      5: r = y >= 8 ? 0 : x * (1 << y);
      6: r = y >= 8 ? 0 : x / (1 << y);
      default: if (men) begin r = x * y; c = r > 255; end else ill = 1;
    endcase
    r8 = r[7:0];
    return {ill, r8 >= 8'd128, r8 == 8'd0, v, c, r8};
  endfunction

  function automatic logic [12:0] obs();
    return {illegal, negative, zero, overflow, carry, result};
  endfunction

  function automatic logic [12:0] n_obs();
    return {n_illegal, n_negative, n_zero, n_overflow, n_carry, n_result};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic [2:0] top, input int stall);
    logic [12:0] exp;
    int lat, w;
    bit rdy_low;
    exp = model(ta, tb, top, 1'b1);
    out_ready = 1'b0;
    a = ta; b = tb; op = top; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 20) begin tick(); w++; end
    chk("accept_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    lat = 1;
    rdy_low = 1'b1;
    while (!out_valid && lat < 40) begin
      rdy_low &= !in_ready;
      tick();
      lat++;
    end
    chk($sformatf("latency op%0d", top), lat, top == 3'd7 ? 9 : 1);
    if (top == 3'd7) chk("mul_in_ready_low", rdy_low, 1);
    chk($sformatf("op%0d %h,%h", top, ta, tb), obs(), exp);
    repeat (stall) tick();
    if (stall > 0) chk("hold", {out_valid, in_ready, obs()}, {2'b10, exp});
    out_ready = 1'b1;
    tick();
    chk("consumed", out_valid, 0);
  endtask

  initial begin
    logic [12:0] e;
    logic [7:0] ra, rb;
    logic [2:0] rop;
    repeat (2) tick();
    chk("reset_state", {out_valid, in_ready, obs()}, 0);
    rst = 1'b0;
    chk("ready_before_edge", in_ready, 0);
    tick();
    chk("ready_after_edge", in_ready, 1);
    // directed vectors
    run_op(8'hFF, 8'h01, 3'd0, 0);
    run_op(8'h80, 8'h01, 3'd1, 0);
    run_op(8'h00, 8'h01, 3'd1, 0);
    run_op(8'h10, 8'h10, 3'd7, 0);
    run_op(8'h0F, 8'h0F, 3'd7, 1);
    run_op(8'h81, 8'h01, 3'd5, 0);
    run_op(8'h80, 8'h09, 3'd6, 0);
    // downstream stall, then back-to-back adds
    out_ready = 1'b0;
    a = 8'h11; b = 8'h22; op = 3'd0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    e = model(8'h11, 8'h22, 0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_hold", {out_valid, in_ready, obs()}, {2'b10, e});
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 8'($urandom); b = 8'($urandom); op = 3'd0; in_valid = 1'b1;
      e = model(a, b, 0, 1'b1);
      tick();
      chk($sformatf("b2b_%0d", i), {out_valid, obs()}, {1'b1, e});
    end
    in_valid = 1'b0;
    tick();
    chk("b2b_drain", out_valid, 0);
    // reset in the middle of a multiply
    run_op(8'h33, 8'h01, 3'd0, 0);
    a = 8'h03; b = 8'h05; op = 3'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1 chk("async_reset", {out_valid, in_ready, obs()}, 0);
    tick();
    rst = 1'b0;
    tick();
    run_op(8'h02, 8'h03, 3'd0, 0);
    chk("post_reset_add", result, 8'h05);
    // random traffic
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = 8'($urandom);
      rb = (rop == 3'd5 || rop == 3'd6) ? 8'($urandom_range(0, 10)) : 8'($urandom);
      run_op(ra, rb, rop, $urandom_range(0, 2));
    end
    // MUL_EN=0 instance: op 111 is illegal, cleared by the next result
    n_a = 8'h05; n_b = 8'h09; n_op = 3'd7; n_in_valid = 1'b1;
    chk("nomul_ready", n_in_ready, 1);
    tick();
    n_in_valid = 1'b0;
    chk("nomul_illegal", {n_out_valid, n_obs()}, {1'b1, model(5, 9, 7, 1'b0)});
    tick();
    n_a = 8'h01; n_b = 8'h01; n_op = 3'd0; n_in_valid = 1'b1;
    tick();
    n_in_valid = 1'b0;
    chk("nomul_cleared", {n_out_valid, n_obs()}, {1'b1, model(1, 1, 0, 1'b0)});
    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end
endmodule
